alu_multicycle: RTL and testbench

//   EX-stage ALU driven by the 4-bit ALU control code. Executes add/sub/and/or
//   in one registered cycle. Executes mul with an iterative shift-add datapath

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_multicycle_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 71 +++++++
 rtl/alu_multicycle.sv | 106 ++++++++++
 tb/tb_alu_multicycle.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM state encoding for alu_multicycle.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_CTRL_MUL = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the EX-stage control and alu_multicycle.
interface alu_multicycle_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic              start_i;
  logic [WIDTH-1:0]  data1_i;
  logic [WIDTH-1:0]  data2_i;
  logic [CTRL_W-1:0] ALUCtrl_i;
  logic [WIDTH-1:0]  data_o;
  logic              zero_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output start_i, data1_i, data2_i, ALUCtrl_i,
    input  data_o, zero_o, valid_o, busy_o
  );

  modport slave (
    input  start_i, data1_i, data2_i, ALUCtrl_i,
    output data_o, zero_o, valid_o, busy_o
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: operand registers, accumulator,
// iteration counter and the exit test. Optional early exit when the remaining
// multiplier bits are all zero is enabled by ALU_MUL_EARLY_EXIT_EN.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_next_c;
  logic [WIDTH-1:0] mplier_next_c;

  // One shift-add iteration and the load/step next-state selection
  always_comb begin
    acc_next_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_next_c = mplier_q >> 1;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    if (start_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_next_c;
      acc_d    = acc_next_c;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Last iteration is the one whose result is being produced this cycle
  always_comb begin
`ifdef ALU_MUL_EARLY_EXIT_EN
    done_c = step_i && ((cnt_q == CNT_W'(WIDTH - 1)) || (mplier_next_c == '0));
`else
    done_c = step_i && (cnt_q == CNT_W'(WIDTH - 1));
`endif
    product_c = acc_next_c;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle and/or/add/sub, multi-cycle shift-add mul with
// busy_o stall. Build option: ALU_MUL_EARLY_EXIT_EN shortens mul when the
// multiplier runs out of set bits (result unchanged).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  alu_multicycle_if.slave        bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             zero_q,  zero_d;
  logic             valid_q, valid_d;

  logic             accept_c;
  logic             mul_start_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_product_c;
  logic [WIDTH-1:0] op_res_c;

  assign accept_c = bus.start_i && (state_q == ST_IDLE);

  // Single-cycle operation result; unknown codes yield zero
  always_comb begin
    op_res_c = '0;
    unique case (bus.ALUCtrl_i)
      ALU_CTRL_AND: op_res_c = bus.data1_i & bus.data2_i;
      ALU_CTRL_OR:  op_res_c = bus.data1_i | bus.data2_i;
      ALU_CTRL_ADD: op_res_c = bus.data1_i + bus.data2_i;
      ALU_CTRL_SUB: op_res_c = bus.data1_i - bus.data2_i;
      default:      op_res_c = '0;
    endcase
  end

  // FSM next state and output register updates
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    zero_d      = zero_q;
    valid_d     = 1'b0;
    mul_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (bus.ALUCtrl_i == ALU_CTRL_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end else begin
            data_d  = op_res_c;
            zero_d  = (op_res_c == '0);
            valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          data_d  = mul_product_c;
          zero_d  = (mul_product_c == '0);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start_c),
    .step_i    (state_q == ST_MUL),
    .mcand_i   (bus.data1_i),
    .mplier_i  (bus.data2_i),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1010: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_busy(input logic [3:0] c, input logic [31:0] b);
    int n;
    n = 32;
`ifdef ALU_MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`endif
    if (c != 4'b1010) n = 0;
    return n;
  endfunction

  // Issue one op at a negedge; return at the negedge where valid_o is seen
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input bit noise);
    logic [31:0] exp;
    int          eb;
    int          nbusy;
    int          lat;
    bit          got;
    exp   = model_result(a, b, c);
    eb    = model_busy(c, b);
    bus.start_i   = 1'b1;
    bus.data1_i   = a;
    bus.data2_i   = b;
    bus.ALUCtrl_i = c;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    nbusy = 0;
    lat   = 0;
    got   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (bus.valid_o) begin
        got = 1'b1;
        break;
      end
      if (bus.busy_o) nbusy++;
      if (noise) begin
        if (nbusy == 1) begin
          bus.start_i   = 1'b1;
          bus.data1_i   = 32'd1;
          bus.data2_i   = 32'd1;
          bus.ALUCtrl_i = ALU_CTRL_ADD;
        end else begin
          bus.start_i = 1'b0;
        end
      end
    end
    bus.start_i = 1'b0;
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(eb + 1));
    check({tag, "_busy"}, 32'(nbusy), 32'(eb));
    check({tag, "_busy_in_valid"}, {31'd0, bus.busy_o}, 32'd0);
    check({tag, "_data"}, bus.data_o, exp);
    check({tag, "_zero"}, {31'd0, bus.zero_o}, {31'd0, exp == 32'd0});
  endtask

  task automatic check_no_valid(input string tag);
    @(negedge clk);
    check(tag, {31'd0, bus.valid_o}, 32'd0);
  endtask

  initial begin
    logic [3:0]  codes [7];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rc;
    int          nvalid;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b1111};
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start_i   = 1'b0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.ALUCtrl_i = '0;
    repeat (3) @(negedge clk);
    check("rst_data",  bus.data_o, 32'd0);
    check("rst_zero",  {31'd0, bus.zero_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;

    run_op("add", 32'd5, 32'd3, ALU_CTRL_ADD, 1'b0);
    check_no_valid("add_pulse");
    run_op("sub_zero", 32'd9, 32'd9, ALU_CTRL_SUB, 1'b0);
    run_op("sub_wrap", 32'd0, 32'd1, ALU_CTRL_SUB, 1'b0);
    run_op("mul", 32'd7, 32'd6, ALU_CTRL_MUL, 1'b0);
    check_no_valid("mul_pulse");
    run_op("mul_wrap", 32'hFFFF_FFFF, 32'd2, ALU_CTRL_MUL, 1'b0);
    run_op("mul_zero", 32'h1234_5678, 32'd0, ALU_CTRL_MUL, 1'b0);
    run_op("unknown", 32'd5, 32'd3, 4'b0111, 1'b0);

    // start during mul (with changed operands) must be ignored
    run_op("busy_ign", 32'd7, 32'd6, ALU_CTRL_MUL, 1'b1);
    check_no_valid("busy_ign_extra");
    check_no_valid("busy_ign_extra2");

    // Back-to-back: or issued in the mul valid cycle
    run_op("b2b_mul", 32'd7, 32'd6, ALU_CTRL_MUL, 1'b0);
    run_op("b2b_or", 32'hF0, 32'h0F, ALU_CTRL_OR, 1'b0);
    check_no_valid("b2b_pulse");

    // Reset during a long mul
    bus.start_i   = 1'b1;
    bus.data1_i   = 32'd7;
    bus.data2_i   = 32'h8000_0000;
    bus.ALUCtrl_i = ALU_CTRL_MUL;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_busy_before", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy",  {31'd0, bus.busy_o}, 32'd0);
    check("rstmid_data",  bus.data_o, 32'd0);
    check("rstmid_zero",  {31'd0, bus.zero_o}, 32'd1);
    check("rstmid_valid", {31'd0, bus.valid_o}, 32'd0);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.valid_o) nvalid++;
    end
    check("rstmid_no_valid", 32'(nvalid), 32'd0);
    run_op("post_rst_add", 32'd100, 32'd23, ALU_CTRL_ADD, 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = codes[$urandom_range(0, 6)];
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb, rc, 1'b0);
    end
    check_no_valid("rnd_end_pulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
